// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-slave SPI master and its SCLK generator.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // A single chip select still needs a one-bit index port.
  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider for the SPI master: ticks every CLK_DIV cycles while enabled,
// toggles sclk on ticks while run is high and flags leading/trailing edges one cycle ahead.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  input  logic level,
  output logic tick,
  output logic lead_stb,
  output logic trail_stb,
  output logic sclk
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  // Strobes mark the clk edge on which sclk changes, so the top samples miso before it moves.
  assign tick      = en && (div_cnt == CW'(CLK_DIV - 1));
  assign lead_stb  = tick && run && (sclk == level);
  assign trail_stb = tick && run && (sclk != level);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + CW'(1);
      if (!en)              sclk <= level;
      else if (tick && run) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: DATA_W-bit words, runtime CPOL/CPHA, NUM_CS decoded chip selects.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first port for LSB-first transfers.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic [cs_width(NUM_CS)-1:0] cs_sel,
  input  logic [DATA_W-1:0]           tx_data,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        busy,
  output logic                        done,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                        lsb_first,
`endif
  output logic [NUM_CS-1:0]           cs_n
);
  localparam int CS_W = cs_width(NUM_CS);
  localparam int HP_W = $clog2(2 * DATA_W);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);

  spi_state_e        state, next;
  spi_mode_t         mode;
  logic              lsb, lsb_req;
  logic [DATA_W-1:0] sh_tx, sh_rx;
  logic [HP_W-1:0]   hp;
  logic              tick, lead_stb, trail_stb;
  logic              accept, last_hp, shift_stb, sample_stb;
  logic              gen_en, gen_run, idle_level;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_req = lsb_first;
`else
  assign lsb_req = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb_mode);
    return lsb_mode ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb_mode);
    return lsb_mode ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb_mode,
                                                 input logic b);
    return lsb_mode ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range indices leave every select high; the transfer still runs.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(sel) == i) r[i] = 1'b0;
    return r;
  endfunction

  assign accept     = (state == IDLE) && start && !busy;
  assign last_hp    = (hp == HP_LAST);
  assign gen_en     = (state != IDLE);
  assign gen_run    = (state == XFER);
  assign idle_level = (state == IDLE) ? cpol : mode.cpol;
  // CPHA=0 skips the final trailing shift so mosi keeps the last bit through HOLD.
  assign shift_stb  = mode.cpha ? lead_stb : (trail_stb && !last_hp);
  assign sample_stb = mode.cpha ? trail_stb : lead_stb;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk       (clk),
    .rst       (rst),
    .en        (gen_en),
    .run       (gen_run),
    .level     (idle_level),
    .tick      (tick),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .sclk      (sclk)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = SETUP;
      SETUP:   if (tick) next = XFER;
      XFER:    if (tick && last_hp) next = HOLD;
      HOLD:    if (tick) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      hp      <= '0;
    end else begin
      busy <= (next != IDLE);
      done <= (state == HOLD) && tick;
      if (accept) begin
        cs_n <= cs_decode(cs_sel);
        hp   <= '0;
        if (!cpha) mosi <= first_bit(tx_data, lsb_req);
      end
      if ((state == XFER) && tick) hp <= hp + HP_W'(1);
      if (shift_stb) mosi <= first_bit(sh_tx, lsb);
      if ((state == HOLD) && tick) begin
        cs_n    <= '1;
        rx_data <= sh_rx;
      end
    end
  end

  // Latched transfer configuration and shift registers carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mode.cpol <= cpol;
      mode.cpha <= cpha;
      lsb       <= lsb_req;
      sh_tx     <= cpha ? tx_data : shift_out(tx_data, lsb_req);
    end else if (shift_stb) begin
      sh_tx <= shift_out(sh_tx, lsb);
    end
    if (sample_stb) sh_rx <= shift_in(sh_rx, lsb, miso);
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: SPI slave model on the pins, randomized words and
// modes, chip-select decode, back-to-back starts and mid-transfer reset.
`timescale 1ns/1ps
module tb_spi_master_multi;
  localparam int DW   = 8;
  localparam int DIV  = 4;
  localparam int NCS  = 4;
  localparam int LAT  = 1 + DIV * (2 * DW + 2);
  localparam int DW3  = 4;
  localparam int DIV3 = 2;
  localparam int NCS3 = 3;
  localparam int LAT3 = 1 + DIV3 * (2 * DW3 + 2);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic loop_mode = 1'b1;
  logic [1:0] cs_sel = '0;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic busy, done, sclk, mosi, miso;
  logic [NCS-1:0] cs_n;

  logic start3 = 1'b0;
  logic [1:0] cs_sel3 = '0;
  logic [DW3-1:0] tx3 = '0;
  logic [DW3-1:0] rx3;
  logic busy3, done3, sclk3, mosi3, miso3;
  logic [NCS3-1:0] cs_n3;

  int n_cmp = 0, n_err = 0;

  // Slave model state (written only by the slave process below, except the arm controls)
  logic s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, slave_armed = 1'b0, slave_bit = 1'b0;
  logic [DW-1:0] slave_word = '0, slave_cap = '0;
  int arm_gen = 0, seen_gen = 0, n_cap = 0, s_next = 0, n_edges = 0;

  assign miso  = loop_mode ? mosi : slave_bit;
  assign miso3 = mosi3;

  spi_master_multi #(.DATA_W(DW), .CLK_DIV(DIV), .NUM_CS(NCS)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk),
    .mosi(mosi), .miso(miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_n(cs_n));

  spi_master_multi #(.DATA_W(DW3), .CLK_DIV(DIV3), .NUM_CS(NCS3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel3),
    .tx_data(tx3), .rx_data(rx3), .busy(busy3), .done(done3), .sclk(sclk3),
    .mosi(mosi3), .miso(miso3),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_n(cs_n3));

  always #5 clk = ~clk;

  function automatic logic word_bit(input logic [DW-1:0] w, input int k, input logic lsb);
    return lsb ? w[k] : w[DW-1-k];
  endfunction

  // Generic SPI slave: drives its word on shift edges, captures mosi on sample edges.
  always @(sclk or arm_gen) begin
    if (arm_gen != seen_gen) begin
      seen_gen  = arm_gen;
      n_cap     = 0;
      n_edges   = 0;
      slave_cap = '0;
      s_next    = s_cpha ? 0 : 1;
      slave_bit = s_cpha ? 1'b0 : word_bit(slave_word, 0, s_lsb);
    end else if (slave_armed) begin
      n_edges++;
      if ((sclk != s_cpol) ^ s_cpha) begin
        if (n_cap < DW) begin
          if (s_lsb) slave_cap[n_cap] = mosi;
          else       slave_cap[DW-1-n_cap] = mosi;
          n_cap++;
        end
      end else if (s_next < DW) begin
        slave_bit = word_bit(slave_word, s_next, s_lsb);
        s_next++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_xfer(input logic m_cpol, input logic m_cpha, input logic [1:0] sel,
                          input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                          input logic loop, input logic lsb);
    int cyc, cs_good;
    logic [NCS-1:0] exp_cs;
    logic [DW-1:0] exp_rx;
    exp_cs = '1;
    exp_cs[sel] = 1'b0;
    exp_rx = loop ? tx : sw;
    cpol = m_cpol; cpha = m_cpha; cs_sel = sel; tx_data = tx; loop_mode = loop; lsb_first = lsb;
    repeat (2) @(posedge clk);
    #1;
    check("idle_sclk", sclk, m_cpol);
    s_cpol = m_cpol; s_cpha = m_cpha; s_lsb = lsb; slave_word = sw;
    slave_armed = 1'b1;
    arm_gen++;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // configuration churn while busy must not disturb the transfer
    cpol = ~m_cpol; cpha = 1'($urandom); cs_sel = 2'($urandom); tx_data = DW'($urandom);
    cyc = 1;
    cs_good = 0;
    while (!done && cyc < LAT + 20) begin
      if (busy && cs_n === exp_cs) cs_good++;
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == 20);
    end
    start = 1'b0;
    slave_armed = 1'b0;
    check("latency", cyc, LAT);
    check("done", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("cs_n_at_done", cs_n, {NCS{1'b1}});
    check("cs_window", cs_good, LAT - 1);
    check("rx_data", rx_data, exp_rx);
    check("slave_got_tx", slave_cap, tx);
    check("sclk_edges", n_edges, 2 * DW);
    check("sclk_end_level", sclk, m_cpol);
    @(posedge clk);
    #1;
    check("done_pulse", done, 1'b0);
    check("no_queue", busy, 1'b0);
    check("rx_hold", rx_data, exp_rx);
    cpol = m_cpol;
  endtask

  task automatic run_x3(input logic [1:0] sel, input logic [DW3-1:0] tx);
    int cyc, cs_good;
    logic [NCS3-1:0] exp_cs;
    exp_cs = '1;
    if (sel < 2'(NCS3)) exp_cs[sel] = 1'b0;
    cpol = 1'b0; cpha = 1'b0; cs_sel3 = sel; tx3 = tx;
    repeat (2) @(posedge clk);
    #1;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    cyc = 1;
    cs_good = 0;
    while (!done3 && cyc < LAT3 + 20) begin
      if (busy3 && cs_n3 === exp_cs) cs_good++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("x3_latency", cyc, LAT3);
    check("x3_done", done3, 1'b1);
    check("x3_cs_window", cs_good, LAT3 - 1);
    check("x3_rx", rx3, tx);
    check("x3_cs_idle", cs_n3, {NCS3{1'b1}});
  endtask

  initial begin
    int cyc, n_done, t1, t2, bad_rx, done_seen;
    logic [DW-1:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, '0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_n", cs_n, {NCS{1'b1}});
    rst = 1'b0;

    // Mode 0 loopback, fixed word
    run_xfer(1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, 1'b0);

    // All four modes against the slave model, fixed and random slave words
    for (int m = 0; m < 4; m++)
      run_xfer(1'(m >> 1), 1'(m), 2'($urandom_range(0, 3)), DW'($urandom), 8'h3C, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++)
      run_xfer(1'(m >> 1), 1'(m), 2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), 1'b0, 1'b0);

    // Chip-select decode, including out-of-range index on a 3-select instance
    run_xfer(1'b0, 1'b1, 2'd2, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    run_x3(2'd3, DW3'($urandom));
    run_x3(2'd1, DW3'($urandom));

    // start held high: back-to-back transfers every LAT cycles
    w = DW'($urandom);
    cpol = 1'b0; cpha = 1'b1; cs_sel = 2'd3; tx_data = w; loop_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1; n_done = 0; t1 = 0; t2 = 0; bad_rx = 0;
    while (cyc <= 200) begin
      if (done) begin
        n_done++;
        if (n_done == 1) t1 = cyc;
        if (n_done == 2) t2 = cyc;
        if (rx_data !== w) bad_rx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("b2b_count", n_done, 200 / LAT);
    check("b2b_first", t1, LAT);
    check("b2b_second", t2, 2 * LAT);
    check("b2b_rx_bad", bad_rx, 0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("b2b_drained", busy, 1'b0);

    // Reset at cycle 30 of a transfer aborts it
    cpol = 1'b1; cpha = 1'b0; cs_sel = 2'd1; tx_data = DW'($urandom); loop_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("abort_mid_busy", busy, 1'b1);
    check("abort_mid_cs", cs_n, 4'b1101);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_cs_n", cs_n, {NCS{1'b1}});
    check("abort_busy", busy, 1'b0);
    check("abort_sclk", sclk, 1'b0);
    check("abort_done", done, 1'b0);
    rst = 1'b0;
    done_seen = 0;
    repeat (LAT + 20) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

`ifdef SPI_MASTER_LSB_FIRST_EN
    // LSB-first: single set bit leaves first; slave word arrives LSB first
    run_xfer(1'b0, 1'b0, 2'd0, 8'h01, 8'h81, 1'b0, 1'b1);
    run_xfer(1'b1, 1'b1, 2'd3, DW'($urandom), DW'($urandom), 1'b0, 1'b1);
    run_xfer(1'b0, 1'b1, 2'd1, DW'($urandom), DW'($urandom), 1'b1, 1'b1);
    run_xfer(1'b1, 1'b0, 2'd2, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
